fp4_fft_result_streamer: RTL and testbench

//  Unload engine for the FP4 FFT result memory: on completion of an FFT it reads all N complex FP4

---
 rtl/fp4_fft_result_streamer.sv | 145 ++++++++++++++
 tb/tb_fp4_fft_result_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp4_fft_result_streamer.sv
// Unloads N complex FP4 FFT results from the result memory and streams them out as valid/ready beats.
// A 2-entry output FIFO absorbs the 1-cycle read latency so continuous m_ready sustains 1 beat/cycle.
module fp4_fft_result_streamer #(
    parameter int MAX_N       = 32,
    parameter int ADDR_WIDTH  = $clog2(MAX_N),
    parameter bit BIT_REV_OUT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_done,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   n_points,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done_unload,
    output logic                  err_overrun
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, n_last, shamt;
    logic [ADDR_WIDTH-1:0] dec_last, dec_shamt, rev_full, addr;
    logic                  inflight, inflight_last;
    logic [ADDR_WIDTH-1:0] inflight_idx;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  hs, last_issue;
    logic [7:0]            tail_data;
    logic [ADDR_WIDTH-1:0] tail_idx;
    logic                  tail_last;

    // Non-power-of-2 or out-of-range lengths fall back to MAX_N.
    always_comb begin
        dec_last  = '1;
        dec_shamt = '0;
        for (int i = 1; i <= ADDR_WIDTH; i++) begin
            if (n_points == (ADDR_WIDTH+1)'(1 << i)) begin
                dec_last  = ADDR_WIDTH'((1 << i) - 1);
                dec_shamt = ADDR_WIDTH'(ADDR_WIDTH - i);
            end
        end
    end

    always_comb begin
        rev_full = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev_full[i] = cnt[ADDR_WIDTH-1-i];
        end
    end

    assign addr    = BIT_REV_OUT ? (rev_full >> shamt) : cnt;
    assign rd_addr = addr;
    assign m_valid = (count != 2'd0);
    assign busy    = (state != IDLE);
    assign hs      = m_valid & m_ready;

    // A beat leaving this cycle frees its slot, which keeps reads flowing without bubbles.
    assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, hs};
    assign rd_en      = !rst && !abort && (state == RUN) && (occ < 3'd2);
    assign last_issue = rd_en && (cnt == n_last);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fft_done && !abort) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (abort) state_nxt = IDLE;
                     else if (hs && m_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            n_last        <= '0;
            shamt         <= '0;
            inflight      <= 1'b0;
            inflight_idx  <= '0;
            inflight_last <= 1'b0;
            count         <= 2'd0;
            m_data        <= '0;
            m_index       <= '0;
            m_last        <= 1'b0;
            tail_data     <= '0;
            tail_idx      <= '0;
            tail_last     <= 1'b0;
            done_unload   <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_unload <= (state == DRAIN) && hs && m_last && !abort;
            if (fft_done && state != IDLE) err_overrun <= 1'b1;
            if (abort) begin
                cnt      <= '0;
                inflight <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (state == IDLE && fft_done) begin
                    n_last <= dec_last;
                    shamt  <= dec_shamt;
                    cnt    <= '0;
                end else if (rd_en) begin
                    cnt <= last_issue ? '0 : cnt + 1'b1;
                end
                inflight      <= rd_en;
                inflight_idx  <= addr;
                inflight_last <= last_issue;
                // Head slot drives the stream outputs directly; tail holds the second entry.
                case ({inflight, hs})
                    2'b10: begin
                        if (count == 2'd0) begin
                            m_data <= rd_data; m_index <= inflight_idx; m_last <= inflight_last;
                        end else begin
                            tail_data <= rd_data; tail_idx <= inflight_idx; tail_last <= inflight_last;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        m_data <= tail_data; m_index <= tail_idx; m_last <= tail_last;
                        count  <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            m_data <= rd_data; m_index <= inflight_idx; m_last <= inflight_last;
                        end else begin
                            m_data    <= tail_data; m_index <= tail_idx; m_last <= tail_last;
                            tail_data <= rd_data; tail_idx <= inflight_idx; tail_last <= inflight_last;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fp4_fft_result_streamer.sv
// Randomized self-checking bench: natural and bit-reversed instances against a queue-based reference.
module tb_fp4_fft_result_streamer;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst, fft_done, abort, m_ready;
    logic [AW:0] n_points;
    logic [AW-1:0] rd_addr0, rd_addr1, m_index0, m_index1;
    logic rd_en0, rd_en1, m_valid0, m_valid1, m_last0, m_last1;
    logic busy0, busy1, done0, done1, err0, err1;
    logic [7:0] rd_data0, rd_data1, m_data0, m_data1;

    fp4_fft_result_streamer #(.MAX_N(32), .BIT_REV_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fft_done(fft_done), .abort(abort), .n_points(n_points),
        .rd_addr(rd_addr0), .rd_en(rd_en0), .rd_data(rd_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .m_data(m_data0), .m_index(m_index0), .m_last(m_last0),
        .busy(busy0), .done_unload(done0), .err_overrun(err0));

    fp4_fft_result_streamer #(.MAX_N(32), .BIT_REV_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .fft_done(fft_done), .abort(abort), .n_points(n_points),
        .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1), .m_valid(m_valid1),
        .m_ready(m_ready), .m_data(m_data1), .m_index(m_index1), .m_last(m_last1),
        .busy(busy1), .done_unload(done1), .err_overrun(err1));

    always #5 clk = ~clk;

    logic [7:0] mem [32];
    always @(posedge clk) begin
        rd_data0 <= mem[rd_addr0];
        rd_data1 <= mem[rd_addr1];
    end

    int checks = 0, failures = 0;
    logic [7:0] obs_data[$], exp_data[$];
    int obs_idx[$], exp_idx[$], obs_addr[$];
    bit obs_last[$], exp_last[$];
    int first_valid, first_rd, last_hs, done_cyc, done_count, stall_viol, max_out, timeout;
    bit ab_mv, ab_busy, ab_done;

    function automatic int rev(input int k, input int l);
        int r = 0;
        for (int b = 0; b < l; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    task automatic build_exp(input int np, input bit brev);
        int n, l;
        n = (np >= 2 && np <= 32 && (np & (np - 1)) == 0) ? np : 32;
        l = $clog2(n);
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
        for (int k = 0; k < n; k++) begin
            int idx = brev ? rev(k, l) : k;
            exp_idx.push_back(idx);
            exp_data.push_back(mem[idx]);
            exp_last.push_back(k == n - 1);
        end
    endtask

    // Drives one unload and records what the selected instance does; judging is left to each test.
    task automatic unload(input int np, input int mode, input bit sel, input int abort_after, input int overrun_at);
        int issued = 0, hsn = 0;
        bit pv = 0, pr = 0, pl = 0, v, l, re, dn, stopped = 0;
        logic [7:0] pd = 0, d;
        int pi = 0, i, ra;
        obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_addr.delete();
        first_valid = -1; first_rd = -1; last_hs = -1; done_cyc = -1; done_count = 0;
        stall_viol = 0; max_out = 0; timeout = 0; ab_mv = 1; ab_busy = 1; ab_done = 0;
        @(posedge clk); #1 fft_done = 1; n_points = (AW+1)'(np); m_ready = 0;
        @(posedge clk); #1 fft_done = 0;
        for (int cyc = 1; cyc <= 400 && !stopped; cyc++) begin
            case (mode)
                0: m_ready = 1;
                1: m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            fft_done = (cyc == overrun_at);
            if (abort_after >= 0 && hsn == abort_after) begin m_ready = 0; abort = 1; end
            @(negedge clk);
            v = sel ? m_valid1 : m_valid0; d = sel ? m_data1 : m_data0;
            i = sel ? int'(m_index1) : int'(m_index0); l = sel ? m_last1 : m_last0;
            re = sel ? rd_en1 : rd_en0; ra = sel ? int'(rd_addr1) : int'(rd_addr0);
            dn = sel ? done1 : done0;
            if (re) begin if (first_rd < 0) first_rd = cyc; obs_addr.push_back(ra); issued++; end
            if (v && first_valid < 0) first_valid = cyc;
            if (pv && !pr && (!v || d !== pd || i != pi || l !== pl)) stall_viol++;
            if (dn) begin done_count++; done_cyc = cyc; stopped = 1; end
            if (abort) begin
                @(posedge clk); #1 abort = 0; fft_done = 0;
                @(negedge clk);
                ab_mv = sel ? m_valid1 : m_valid0; ab_busy = sel ? busy1 : busy0;
                for (int w = 0; w < 4; w++) begin
                    if (sel ? done1 : done0) ab_done = 1;
                    @(negedge clk);
                end
                stopped = 1;
            end else begin
                if (v && m_ready) begin
                    obs_data.push_back(d); obs_idx.push_back(i); obs_last.push_back(l);
                    hsn++; last_hs = cyc;
                end
                if (issued - hsn > max_out) max_out = issued - hsn;
                pv = v; pr = m_ready; pd = d; pi = i; pl = l;
                if (!stopped) begin @(posedge clk); #1; end
            end
        end
        if (!stopped) timeout = 1;
        fft_done = 0; m_ready = 0; abort = 0;
    endtask

    task automatic test_reset;
        rst = 1; fft_done = 1; abort = 0; m_ready = 0; n_points = 8;
        repeat (2) @(posedge clk);
        #1 rst = 0; fft_done = 0;
        @(negedge clk);
        checks++;
        if ({m_valid0, rd_en0, busy0, done0, err0, m_last0, m_data0, m_index0, rd_addr0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b en=%b busy=%b done=%b err=%b data=%h idx=%0d addr=%0d expected all 0",
                     m_valid0, rd_en0, busy0, done0, err0, m_data0, m_index0, rd_addr0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || m_valid0 !== 1'b0) begin
            failures++; $display("FAIL reset_ignores_fft_done got busy=%b valid=%b expected 0 0", busy0, m_valid0);
        end
    endtask

    task automatic check_beats(input string name);
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++; $display("FAIL %s_count got %0d beats expected %0d", name, obs_data.size(), exp_data.size());
        end
        for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
            checks++;
            if (obs_data[k] !== exp_data[k] || obs_idx[k] != exp_idx[k] || obs_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL %s_beat%0d got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                         name, k, obs_data[k], obs_idx[k], obs_last[k], exp_data[k], exp_idx[k], exp_last[k]);
            end
        end
        checks++;
        if (timeout != 0 || done_count != 1 || done_cyc != last_hs + 1) begin
            failures++;
            $display("FAIL %s_done got timeout=%0d done_count=%0d done_cyc=%0d expected 0 1 %0d",
                     name, timeout, done_count, done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_natural;
        for (int k = 0; k < 32; k++) mem[k] = 8'(k * 3);
        unload(8, 0, 0, -1, -1);
        build_exp(8, 0);
        check_beats("natural");
        checks++;
        if (first_rd != 1 || first_valid != 3) begin
            failures++; $display("FAIL natural_latency got rd=%0d valid=%0d expected 1 3", first_rd, first_valid);
        end
        checks++;
        if (last_hs - first_valid + 1 != 8) begin
            failures++; $display("FAIL natural_bubbles got span=%0d expected 8", last_hs - first_valid + 1);
        end
    endtask

    task automatic test_stall;
        unload(8, 1, 0, -1, -1);
        build_exp(8, 0);
        check_beats("stall");
        checks++;
        if (stall_viol != 0 || max_out > 2) begin
            failures++; $display("FAIL stall_rules got violations=%0d max_out=%0d expected 0 <=2", stall_viol, max_out);
        end
    endtask

    task automatic test_bitrev;
        unload(8, 0, 1, -1, -1);
        build_exp(8, 1);
        check_beats("bitrev");
        checks++;
        if (obs_addr.size() != 8) begin
            failures++; $display("FAIL bitrev_addr_count got %0d expected 8", obs_addr.size());
        end
        for (int k = 0; k < 8 && k < obs_addr.size(); k++) begin
            checks++;
            if (obs_addr[k] != exp_idx[k]) begin
                failures++; $display("FAIL bitrev_addr%0d got %0d expected %0d", k, obs_addr[k], exp_idx[k]);
            end
        end
    endtask

    task automatic test_random;
        int choices[8] = '{2, 4, 16, 32, 8, 0, 5, 33};
        for (int it = 0; it < 8; it++) begin
            int np = choices[$urandom_range(0, 7)];
            bit sel = 1'($urandom_range(0, 1));
            for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
            unload(np, 2, sel, -1, -1);
            build_exp(np, sel);
            check_beats("random");
            checks++;
            if (stall_viol != 0 || max_out > 2) begin
                failures++; $display("FAIL random_rules np=%0d got violations=%0d max_out=%0d", np, stall_viol, max_out);
            end
        end
    endtask

    task automatic test_overrun;
        for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
        checks++;
        if (err0 !== 1'b0) begin failures++; $display("FAIL overrun_pre got %b expected 0", err0); end
        unload(12, 0, 0, -1, 10);
        build_exp(12, 0);
        check_beats("overrun");
        checks++;
        if (err0 !== 1'b1) begin failures++; $display("FAIL overrun_flag got %b expected 1", err0); end
    endtask

    task automatic test_abort;
        for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
        unload(8, 0, 0, 3, -1);
        checks++;
        if (ab_mv !== 1'b0 || ab_busy !== 1'b0 || ab_done !== 1'b0 || obs_data.size() != 3) begin
            failures++;
            $display("FAIL abort_flush got valid=%b busy=%b done=%b beats=%0d expected 0 0 0 3",
                     ab_mv, ab_busy, ab_done, obs_data.size());
        end
        unload(8, 0, 0, -1, -1);
        build_exp(8, 0);
        check_beats("restart");
        checks++;
        if (err0 !== 1'b1) begin failures++; $display("FAIL overrun_sticky got %b expected 1", err0); end
    endtask

    initial begin
        rst = 1; fft_done = 0; abort = 0; m_ready = 0; n_points = 0;
        for (int k = 0; k < 32; k++) mem[k] = 8'd0;
        test_reset();
        test_natural();
        test_stall();
        test_bitrev();
        test_random();
        test_overrun();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
